local_access_router: RTL and testbench
======================================

LOCAL_ACCESS_ROUTER -- requirements
Module: local_access_router

Interface
REQ-001 Parameter N_LOCAL, default 5: number of local register-access ports, range 1..8.
REQ-002 Parameter N_EXT, default 3: number of external TSS/TSE command channels, range 0..7; N_LOCAL+N_EXT SHALL be at most 16.
REQ-003 Parameter FIFO_DEPTH, default 4: command FIFO depth, a power of two, range 2..16.
REQ-004 Parameter TIMEOUT_CYC, default 1023: maximum wait for a read response.
REQ-005 Ports SHALL be as follows; one clock; reset is synchronous and active-low.
- i_clk, in, 1: clock.
- i_rst_n, in, 1: synchronous active-low reset.
- iv_command, in, 66: request.
- i_command_wr, in, 1: request strobe.
- ov_command_ack, out, 66: response.
- o_command_ack_wr, out, 1: response strobe.
- ov_lcl_wr, out, N_LOCAL: per-port write strobe.
- ov_lcl_rd, out, N_LOCAL: per-port read strobe.
- ov_lcl_wdata, out, 32: shared write data.
- ov_lcl_addr, out, 19: shared address.
- o_lcl_addr_fix, out, 1: shared address-fix flag.
- iv_lcl_rvalid, in, N_LOCAL: per-port read-return strobe.
- iv_lcl_raddr, in, 19*N_LOCAL: packed per-port read-return address.
- iv_lcl_addr_fix, in, N_LOCAL: per-port read-return address-fix flag.
- iv_lcl_rdata, in, 32*N_LOCAL: packed per-port read-return data.
- ov_ext_command, out, 64*N_EXT: packed external commands.
- ov_ext_command_wr, out, N_EXT: external command strobes.
- iv_ext_ack, in, 64*N_EXT: packed external acks.
- iv_ext_ack_wr, in, N_EXT: external ack strobes.
- ov_drop_cnt, out, 16: saturating count of dropped requests.
- ov_timeout_cnt, out, 16: saturating count of timeouts.

Function
REQ-006 Request fields SHALL be: [65:64] opcode (01 write, 10 read, other illegal); [63:60] target id; [59] addr_fix; [50:32] addr; [31:0] data.
- Target ids 0..N_LOCAL-1 SHALL select local ports.
- Target ids N_LOCAL..N_LOCAL+N_EXT-1 SHALL select external channels.
REQ-007 i_command_wr while the FIFO is full SHALL drop the request and increment ov_drop_cnt, even if a pop occurs in the same cycle.
REQ-008 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP; only one transaction SHALL be outstanding at a time.
REQ-009 In IDLE with the FIFO non-empty, the FSM SHALL pop one entry and go to ISSUE.
- For a request written into an empty FIFO while IDLE, the target strobe SHALL assert exactly 2 cycles after i_command_wr.
REQ-010 ISSUE SHALL drive exactly one strobe for exactly one cycle.
- Local write: the ov_lcl_wr bit, then IDLE, with no ack.
- Local read: the ov_lcl_rd bit, then WAIT.
- External write: the ov_ext_command_wr bit carrying iv_command[63:0], then IDLE.
- External read: the same external strobe, then WAIT.
REQ-011 In WAIT, only the strobe of the addressed port or channel SHALL be accepted; all others SHALL be ignored.
- On acceptance the FSM SHALL capture the response and enter RESP.
- o_command_ack_wr SHALL pulse the cycle after capture.
REQ-012 Local read ack SHALL be: [65:64]=00, [63:60]=id, [59]=returned addr_fix, [58:51]=0, [50:32]=returned raddr, [31:0]=rdata.
REQ-013 External ack SHALL be {2'b00, iv_ext_ack slice}.
REQ-014 An illegal opcode or out-of-range id SHALL drive no strobe and SHALL pass through RESP with an error ack: [65:64]=11, [63:0]=request[63:0].
REQ-015 RESP SHALL last one cycle, then return to IDLE.
REQ-016 Both counters SHALL saturate at 0xFFFF.

Reset
REQ-017 While i_rst_n is low at a rising edge, all strobes, ack data, and counters SHALL be 0, the FIFO SHALL be emptied, and the FSM SHALL be in IDLE.
REQ-018 Reset in WAIT SHALL abandon the transaction without an ack; a stale response arriving after reset SHALL be ignored.

Configuration
REQ-019 With ACCESS_TIMEOUT_EN defined, WAIT SHALL count cycles; after TIMEOUT_CYC cycles without a response it SHALL enter RESP with an error ack ([65:64]=11, [63:0]=request[63:0]) and increment ov_timeout_cnt.
- A response arriving in the same cycle as expiry SHALL win.
REQ-020 Without ACCESS_TIMEOUT_EN, WAIT SHALL be unbounded and ov_timeout_cnt SHALL be tied to 0.

Structure
REQ-021 Package local_access_pkg SHALL hold the opcode constants, field bit positions, ack status codes, and the FSM state encoding.
REQ-022 The FIFO SHALL be sub-module lac_cmd_fifo: registered, first-word-fall-through, with full/empty outputs.

Verification
REQ-023 Local write, id 2, addr 0x00010, data 0xA5A5A5A5: ov_lcl_wr=5'b00100 two cycles later for one cycle; no ack.
REQ-024 Local read, id 0, addr 0x00004; return rdata 0x12345678 after 3 cycles: ack 0x0_00004_12345678 with status 00 one cycle after the return.
REQ-025 External read to id 6 with N_LOCAL=5: forwarded on channel 1; an ack on channel 0 is ignored; an ack on channel 1 with value 0x1 is forwarded as {00, 0x1}.
REQ-026 Five back-to-back local writes with FIFO_DEPTH=4 and the FSM busy: exactly one write dropped, ov_drop_cnt=1, four writes issued in order.
REQ-027 With ACCESS_TIMEOUT_EN and TIMEOUT_CYC=8, a read with no response: error ack after 8 WAIT cycles and ov_timeout_cnt=1.
- Additional case: reset asserted in WAIT produces no ack.

Source files
------------

// File: rtl/local_access_pkg.sv
// rtl/local_access_pkg.sv - opcode, field position, ack status and FSM encodings for local_access_router
package local_access_pkg;

  localparam int CMD_W   = 66;
  localparam int OP_HI   = 65;
  localparam int OP_LO   = 64;
  localparam int ID_HI   = 63;
  localparam int ID_LO   = 60;
  localparam int FIX_BIT = 59;
  localparam int ADDR_HI = 50;
  localparam int ADDR_LO = 32;
  localparam int DATA_HI = 31;
  localparam int DATA_LO = 0;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam logic [1:0] ACK_OK  = 2'b00;
  localparam logic [1:0] ACK_ERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/lac_cmd_fifo.sv
// rtl/lac_cmd_fifo.sv - registered first-word-fall-through command FIFO with full/empty flags
module lac_cmd_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] iv_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] ov_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  // Extra pointer bit separates full from empty when the indices coincide.
  assign o_empty  = (wr_ptr_q == rd_ptr_q);
  assign o_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign ov_rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_push && !o_full) begin
      mem_d[wr_ptr_q[AW-1:0]] = iv_wdata;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (i_pop && !o_empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/local_access_router.sv
// rtl/local_access_router.sv - routes 66-bit register commands to local ports or external channels, one at a time
// Optional ACCESS_TIMEOUT_EN bounds the read-response wait to TIMEOUT_CYC cycles.
module local_access_router
  import local_access_pkg::*;
#(
  parameter int N_LOCAL     = 5,
  parameter int N_EXT       = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [65:0]           iv_command,
  input  logic                  i_command_wr,
  output logic [65:0]           ov_command_ack,
  output logic                  o_command_ack_wr,
  output logic [N_LOCAL-1:0]    ov_lcl_wr,
  output logic [N_LOCAL-1:0]    ov_lcl_rd,
  output logic [31:0]           ov_lcl_wdata,
  output logic [18:0]           ov_lcl_addr,
  output logic                  o_lcl_addr_fix,
  input  logic [N_LOCAL-1:0]    iv_lcl_rvalid,
  input  logic [19*N_LOCAL-1:0] iv_lcl_raddr,
  input  logic [N_LOCAL-1:0]    iv_lcl_addr_fix,
  input  logic [32*N_LOCAL-1:0] iv_lcl_rdata,
  output logic [64*N_EXT-1:0]   ov_ext_command,
  output logic [N_EXT-1:0]      ov_ext_command_wr,
  input  logic [64*N_EXT-1:0]   iv_ext_ack,
  input  logic [N_EXT-1:0]      iv_ext_ack_wr,
  output logic [15:0]           ov_drop_cnt,
  output logic [15:0]           ov_timeout_cnt
);

  localparam logic [4:0]  N_LOCAL_5 = 5'(N_LOCAL);
  localparam logic [4:0]  N_TOTAL_5 = 5'(N_LOCAL + N_EXT);
  localparam logic [3:0]  N_LOCAL_4 = 4'(N_LOCAL);
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;
  localparam logic [15:0] CNT_ONE   = 16'd1;

  state_e            state_q, state_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [CMD_W-1:0]  ack_q, ack_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic              fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0]  fifo_rdata;

  logic [1:0]        op;
  logic [3:0]        id;
  logic [3:0]        ext_ch;
  logic              is_local, is_ext, is_read, legal;
  logic [N_LOCAL-1:0] lcl_sel;
  logic [N_EXT-1:0]  ext_sel;
  logic              resp_hit;
  logic [CMD_W-1:0]  resp_ack;

`ifdef ACCESS_TIMEOUT_EN
  localparam int          TW           = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] WAIT_ONE     = TW'(1);
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]   timeout_cnt_q, timeout_cnt_d;
`endif

  lac_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_push   (i_command_wr),
    .iv_wdata (iv_command),
    .i_pop    (fifo_pop),
    .ov_rdata (fifo_rdata),
    .o_full   (fifo_full),
    .o_empty  (fifo_empty)
  );

  assign op       = cmd_q[OP_HI:OP_LO];
  assign id       = cmd_q[ID_HI:ID_LO];
  assign ext_ch   = id - N_LOCAL_4;
  assign is_local = ({1'b0, id} < N_LOCAL_5);
  assign is_ext   = ({1'b0, id} >= N_LOCAL_5) && ({1'b0, id} < N_TOTAL_5);
  assign is_read  = (op == OP_READ);
  assign legal    = ((op == OP_WRITE) || (op == OP_READ)) && (is_local || is_ext);

  always_comb begin
    lcl_sel = '0;
    ext_sel = '0;
    for (int i = 0; i < N_LOCAL; i++) begin
      lcl_sel[i] = is_local && (id == 4'(i));
    end
    for (int i = 0; i < N_EXT; i++) begin
      ext_sel[i] = is_ext && (ext_ch == 4'(i));
    end
  end

  // Only the addressed port or channel can complete the outstanding read.
  always_comb begin
    resp_hit = 1'b0;
    resp_ack = '0;
    for (int i = 0; i < N_LOCAL; i++) begin
      if (lcl_sel[i] && iv_lcl_rvalid[i]) begin
        resp_hit = 1'b1;
        resp_ack = {ACK_OK, id, iv_lcl_addr_fix[i], 8'd0,
                    iv_lcl_raddr[i*19 +: 19], iv_lcl_rdata[i*32 +: 32]};
      end
    end
    for (int i = 0; i < N_EXT; i++) begin
      if (ext_sel[i] && iv_ext_ack_wr[i]) begin
        resp_hit = 1'b1;
        resp_ack = {ACK_OK, iv_ext_ack[i*64 +: 64]};
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    ack_d      = ack_q;
    drop_cnt_d = drop_cnt_q;
    fifo_pop   = 1'b0;
`ifdef ACCESS_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
`endif
    // A full FIFO drops the request even when a pop frees a slot this cycle.
    if (i_command_wr && fifo_full && (drop_cnt_q != CNT_MAX)) begin
      drop_cnt_d = drop_cnt_q + CNT_ONE;
    end
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_rdata;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!legal) begin
          ack_d   = {ACK_ERR, cmd_q[ID_HI:DATA_LO]};
          state_d = ST_RESP;
        end else if (is_read) begin
          state_d = ST_WAIT;
`ifdef ACCESS_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (resp_hit) begin
          ack_d   = resp_ack;
          state_d = ST_RESP;
        end
`ifdef ACCESS_TIMEOUT_EN
        else if (wait_cnt_q == TIMEOUT_LAST) begin
          ack_d   = {ACK_ERR, cmd_q[ID_HI:DATA_LO]};
          state_d = ST_RESP;
          if (timeout_cnt_q != CNT_MAX) begin
            timeout_cnt_d = timeout_cnt_q + CNT_ONE;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      ack_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      ack_q      <= ack_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef ACCESS_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wait_cnt_q    <= '0;
      timeout_cnt_q <= '0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end
  assign ov_timeout_cnt = timeout_cnt_q;
`else
  assign ov_timeout_cnt = '0;
`endif

  assign ov_lcl_wr         = (state_q == ST_ISSUE && legal && is_local && !is_read) ? lcl_sel : '0;
  assign ov_lcl_rd         = (state_q == ST_ISSUE && legal && is_local && is_read) ? lcl_sel : '0;
  assign ov_ext_command_wr = (state_q == ST_ISSUE && legal && is_ext) ? ext_sel : '0;
  assign ov_ext_command    = {N_EXT{cmd_q[ID_HI:DATA_LO]}};
  assign ov_lcl_wdata      = cmd_q[DATA_HI:DATA_LO];
  assign ov_lcl_addr       = cmd_q[ADDR_HI:ADDR_LO];
  assign o_lcl_addr_fix    = cmd_q[FIX_BIT];
  assign ov_command_ack    = ack_q;
  assign o_command_ack_wr  = (state_q == ST_RESP);
  assign ov_drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_local_access_router.sv
// tb/tb_local_access_router.sv - scoreboard bench for local_access_router (timeout case when ACCESS_TIMEOUT_EN is defined)
module tb_local_access_router;

  localparam int NL = 5;
  localparam int NE = 3;
  localparam logic [1:0] OPW = 2'b01;
  localparam logic [1:0] OPR = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [65:0]       cmd;
  logic              cmd_wr;
  logic [65:0]       ack;
  logic              ack_wr;
  logic [NL-1:0]     lcl_wr, lcl_rd;
  logic [31:0]       lcl_wdata;
  logic [18:0]       lcl_addr;
  logic              lcl_fix;
  logic [NL-1:0]     lcl_rvalid;
  logic [19*NL-1:0]  lcl_raddr;
  logic [NL-1:0]     lcl_rfix;
  logic [32*NL-1:0]  lcl_rdata;
  logic [64*NE-1:0]  ext_cmd;
  logic [NE-1:0]     ext_wr;
  logic [64*NE-1:0]  ext_ack;
  logic [NE-1:0]     ext_ack_wr;
  logic [15:0]       drop_cnt, timeout_cnt;

  local_access_router #(
    .N_LOCAL(NL), .N_EXT(NE), .FIFO_DEPTH(4), .TIMEOUT_CYC(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .iv_command(cmd), .i_command_wr(cmd_wr),
    .ov_command_ack(ack), .o_command_ack_wr(ack_wr),
    .ov_lcl_wr(lcl_wr), .ov_lcl_rd(lcl_rd),
    .ov_lcl_wdata(lcl_wdata), .ov_lcl_addr(lcl_addr), .o_lcl_addr_fix(lcl_fix),
    .iv_lcl_rvalid(lcl_rvalid), .iv_lcl_raddr(lcl_raddr),
    .iv_lcl_addr_fix(lcl_rfix), .iv_lcl_rdata(lcl_rdata),
    .ov_ext_command(ext_cmd), .ov_ext_command_wr(ext_wr),
    .iv_ext_ack(ext_ack), .iv_ext_ack_wr(ext_ack_wr),
    .ov_drop_cnt(drop_cnt), .ov_timeout_cnt(timeout_cnt)
  );

  typedef struct {
    logic [NL-1:0] wr;
    logic [NL-1:0] rd;
    logic [18:0]   addr;
    logic [31:0]   data;
  } lcl_exp_t;

  typedef struct {
    logic [NE-1:0] wr;
    logic [63:0]   cmd;
  } ext_exp_t;

  lcl_exp_t    lcl_q[$];
  ext_exp_t    ext_q[$];
  logic [65:0] ack_q[$];
  int checks = 0;
  int failures = 0;
  int ack_cnt = 0;

  lcl_exp_t    m_l;
  ext_exp_t    m_e;
  logic [65:0] m_a;
  int          m_ch;

  function automatic logic [65:0] mk(input logic [1:0] op, input logic [3:0] id, input logic fix,
                                     input logic [18:0] addr, input logic [31:0] data);
    return {op, id, fix, 8'd0, addr, data};
  endfunction

  function automatic lcl_exp_t lexp(input logic [65:0] c);
    lcl_exp_t e;
    e.wr   = '0;
    e.rd   = '0;
    if (c[65:64] == OPW) e.wr[c[63:60]] = 1'b1;
    else                 e.rd[c[63:60]] = 1'b1;
    e.addr = c[50:32];
    e.data = c[31:0];
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if ((|lcl_wr) || (|lcl_rd)) begin
        checks++;
        if (lcl_q.size() == 0) begin
          failures++;
          $display("FAIL lcl_unexpected got wr=%b rd=%b addr=%h required no strobe", lcl_wr, lcl_rd, lcl_addr);
        end else begin
          m_l = lcl_q.pop_front();
          if ({lcl_wr, lcl_rd, lcl_addr, lcl_wdata} !== {m_l.wr, m_l.rd, m_l.addr, m_l.data}) begin
            failures++;
            $display("FAIL lcl_strobe got wr=%b rd=%b addr=%h data=%h required wr=%b rd=%b addr=%h data=%h",
                     lcl_wr, lcl_rd, lcl_addr, lcl_wdata, m_l.wr, m_l.rd, m_l.addr, m_l.data);
          end
        end
      end
      if (|ext_wr) begin
        checks++;
        if (ext_q.size() == 0) begin
          failures++;
          $display("FAIL ext_unexpected got wr=%b required no strobe", ext_wr);
        end else begin
          m_e  = ext_q.pop_front();
          m_ch = 0;
          for (int i = 0; i < NE; i++) if (m_e.wr[i]) m_ch = i;
          if (ext_wr !== m_e.wr || ext_cmd[m_ch*64 +: 64] !== m_e.cmd) begin
            failures++;
            $display("FAIL ext_strobe got wr=%b cmd=%h required wr=%b cmd=%h",
                     ext_wr, ext_cmd[m_ch*64 +: 64], m_e.wr, m_e.cmd);
          end
        end
      end
      if (ack_wr) begin
        ack_cnt++;
        checks++;
        if (ack_q.size() == 0) begin
          failures++;
          $display("FAIL ack_unexpected got %h required no ack", ack);
        end else begin
          m_a = ack_q.pop_front();
          if (ack !== m_a) begin
            failures++;
            $display("FAIL ack_value got %h required %h", ack, m_a);
          end
        end
      end
    end
  end

  task automatic send(input logic [65:0] c);
    @(posedge clk); #1;
    cmd    = c;
    cmd_wr = 1'b1;
    @(posedge clk); #1;
    cmd_wr = 1'b0;
  endtask

  task automatic wait_strobe(input string name);
    bit seen = 0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if ((|lcl_wr) || (|lcl_rd) || (|ext_wr)) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_strobe_wait got no strobe required strobe within 30 cycles", name);
    end
  endtask

  task automatic wait_ack(input string name, input int target);
    for (int n = 0; n < 40 && ack_cnt < target; n++) @(negedge clk);
    checks++;
    if (ack_cnt < target) begin
      failures++;
      $display("FAIL %s_ack_wait got %0d acks required %0d", name, ack_cnt, target);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 40 && (lcl_q.size() != 0 || ext_q.size() != 0); n++) @(negedge clk);
    checks++;
    if (lcl_q.size() != 0 || ext_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got lcl=%0d ext=%0d pending required 0", name, lcl_q.size(), ext_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd = '0; cmd_wr = 1'b0;
    lcl_rvalid = '0; lcl_raddr = '0; lcl_rfix = '0; lcl_rdata = '0;
    ext_ack = '0; ext_ack_wr = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({lcl_wr, lcl_rd, ext_wr, ack_wr, ack, drop_cnt, timeout_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_state got wr=%b rd=%b ext=%b ackwr=%b ack=%h drop=%h to=%h required all 0",
               lcl_wr, lcl_rd, ext_wr, ack_wr, ack, drop_cnt, timeout_cnt);
    end
    cmd = mk(OPW, 4'd1, 1'b0, 19'h1, 32'h1); cmd_wr = 1'b1;
    @(posedge clk); #1;
    cmd_wr = 1'b0;
    rst_n  = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_local_write();
    logic [65:0] c;
    int a0 = ack_cnt;
    c = mk(OPW, 4'd2, 1'b0, 19'h00010, 32'hA5A5A5A5);
    lcl_q.push_back(lexp(c));
    @(posedge clk); #1;
    cmd = c; cmd_wr = 1'b1;
    @(posedge clk); #1;
    cmd_wr = 1'b0;
    checks++;
    if (lcl_wr !== 5'b00000) begin
      failures++; $display("FAIL wr_early got %b required 00000", lcl_wr);
    end
    @(posedge clk); #1;
    checks++;
    if (lcl_wr !== 5'b00100) begin
      failures++; $display("FAIL wr_latency got %b required 00100", lcl_wr);
    end
    @(posedge clk); #1;
    checks++;
    if (lcl_wr !== 5'b00000) begin
      failures++; $display("FAIL wr_one_cycle got %b required 00000", lcl_wr);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ack_cnt !== a0) begin
      failures++; $display("FAIL wr_no_ack got %0d acks required %0d", ack_cnt, a0);
    end
  endtask

  task automatic test_local_read();
    logic [65:0] c;
    c = mk(OPR, 4'd0, 1'b0, 19'h00004, 32'h0);
    lcl_q.push_back(lexp(c));
    ack_q.push_back({2'b00, 4'd0, 1'b0, 8'd0, 19'h00004, 32'h12345678});
    send(c);
    wait_strobe("rd");
    repeat (3) begin
      @(posedge clk); #1;
    end
    lcl_rvalid[0] = 1'b1; lcl_raddr[18:0] = 19'h00004; lcl_rfix[0] = 1'b0; lcl_rdata[31:0] = 32'h12345678;
    @(posedge clk); #1;
    lcl_rvalid = '0;
    checks++;
    if (ack_wr !== 1'b1 || ack !== 66'h0_0000_4_12345678) begin
      failures++; $display("FAIL rd_ack_timing got wr=%b ack=%h required 1 %h", ack_wr, ack, 66'h0_0000_4_12345678);
    end
    @(posedge clk); #1;
    checks++;
    if (ack_wr !== 1'b0) begin
      failures++; $display("FAIL rd_ack_one_cycle got %b required 0", ack_wr);
    end
  endtask

  task automatic test_ext_read();
    logic [65:0] c;
    int a0;
    c = mk(OPR, 4'd6, 1'b1, 19'h7ABCD, 32'hCAFEF00D);
    ext_q.push_back('{3'b010, c[63:0]});
    send(c);
    wait_strobe("ext");
    a0 = ack_cnt;
    @(posedge clk); #1;
    ext_ack[63:0] = 64'hDEAD; ext_ack_wr = 3'b001;
    @(posedge clk); #1;
    ext_ack_wr = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ack_cnt !== a0 || ack_wr !== 1'b0) begin
      failures++; $display("FAIL ext_wrong_channel got %0d acks required %0d", ack_cnt, a0);
    end
    ack_q.push_back({2'b00, 64'h1});
    ext_ack[127:64] = 64'h1; ext_ack_wr = 3'b010;
    @(posedge clk); #1;
    ext_ack_wr = '0;
    wait_ack("ext", a0 + 1);
  endtask

  task automatic test_illegal_and_bounds();
    logic [65:0] c;
    logic [65:0] bad [3];
    bad[0] = mk(2'b11, 4'd0, 1'b0, 19'h00100, 32'h11112222);
    bad[1] = mk(2'b00, 4'd1, 1'b1, 19'h00200, 32'h33334444);
    bad[2] = mk(OPW,   4'd8, 1'b0, 19'h00300, 32'h55556666);
    for (int i = 0; i < 3; i++) begin
      int a0 = ack_cnt;
      ack_q.push_back({2'b11, bad[i][63:0]});
      send(bad[i]);
      wait_ack("illegal", a0 + 1);
    end
    c = mk(OPW, 4'd7, 1'b0, 19'h00400, 32'h77778888);
    ext_q.push_back('{3'b100, c[63:0]});
    send(c);
    c = mk(OPW, 4'd4, 1'b1, 19'h00500, 32'h9999AAAA);
    lcl_q.push_back(lexp(c));
    send(c);
    wait_drain("bounds");
  endtask

  task automatic test_back_to_back();
    logic [65:0] c;
    int a0 = ack_cnt;
    logic [15:0] d0 = drop_cnt;
    c = mk(OPR, 4'd1, 1'b0, 19'h00020, 32'h0);
    lcl_q.push_back(lexp(c));
    send(c);
    wait_strobe("b2b_rd");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cmd    = mk(OPW, 4'(i), 1'b0, 19'h00100 + 19'(i), 32'h1000 + 32'(i));
      cmd_wr = 1'b1;
      if (i < 4) lcl_q.push_back(lexp(cmd));
    end
    @(posedge clk); #1;
    cmd_wr = 1'b0;
    checks++;
    if (drop_cnt !== d0 + 16'd1) begin
      failures++; $display("FAIL b2b_drop_cnt got %0d required %0d", drop_cnt, d0 + 16'd1);
    end
    ack_q.push_back({2'b00, 4'd1, 1'b1, 8'd0, 19'h00020, 32'h55AA55AA});
    lcl_rvalid[1] = 1'b1; lcl_raddr[37:19] = 19'h00020; lcl_rfix[1] = 1'b1; lcl_rdata[63:32] = 32'h55AA55AA;
    @(posedge clk); #1;
    lcl_rvalid = '0;
    wait_ack("b2b", a0 + 1);
    wait_drain("b2b");
  endtask

  task automatic test_wait_bound();
    logic [65:0] c;
    int a0;
    c = mk(OPR, 4'd3, 1'b0, 19'h00033, 32'h0);
    lcl_q.push_back(lexp(c));
`ifdef ACCESS_TIMEOUT_EN
    begin
      int n = 0;
      bit got = 0;
      ack_q.push_back({2'b11, c[63:0]});
      send(c);
      wait_strobe("to");
      while (!got && n < 30) begin
        @(negedge clk);
        n++;
        if (ack_wr) got = 1;
      end
      checks++;
      if (!got || n != 9) begin
        failures++; $display("FAIL timeout_latency got %0d cycles required 9", n);
      end
      checks++;
      if (timeout_cnt !== 16'd1) begin
        failures++; $display("FAIL timeout_cnt got %0d required 1", timeout_cnt);
      end
    end
`else
    send(c);
    wait_strobe("nto");
    a0 = ack_cnt;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (ack_cnt !== a0 || timeout_cnt !== 16'd0) begin
      failures++; $display("FAIL unbounded_wait got acks=%0d to=%0d required acks=%0d to=0", ack_cnt, timeout_cnt, a0);
    end
    ack_q.push_back({2'b00, 4'd3, 1'b0, 8'd0, 19'h00033, 32'hFEEDBEEF});
    lcl_rvalid[3] = 1'b1; lcl_raddr[75:57] = 19'h00033; lcl_rfix[3] = 1'b0; lcl_rdata[127:96] = 32'hFEEDBEEF;
    @(posedge clk); #1;
    lcl_rvalid = '0;
    wait_ack("nto", a0 + 1);
`endif
  endtask

  task automatic test_reset_in_wait();
    logic [65:0] c;
    int a0;
    c = mk(OPR, 4'd4, 1'b0, 19'h00044, 32'h0);
    lcl_q.push_back(lexp(c));
    send(c);
    wait_strobe("rst");
    a0 = ack_cnt;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (drop_cnt !== 16'd0 || timeout_cnt !== 16'd0 || ack !== '0 || ack_wr !== 1'b0) begin
      failures++; $display("FAIL rst_wait_clear got drop=%0d to=%0d ack=%h required 0", drop_cnt, timeout_cnt, ack);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    lcl_rvalid[4] = 1'b1; lcl_raddr[94:76] = 19'h00044; lcl_rdata[159:128] = 32'hBAD0BAD0;
    @(posedge clk); #1;
    lcl_rvalid = '0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (ack_cnt !== a0) begin
      failures++; $display("FAIL rst_stale_ack got %0d acks required %0d", ack_cnt, a0);
    end
    c = mk(OPW, 4'd3, 1'b0, 19'h00055, 32'h0BADCAFE);
    lcl_q.push_back(lexp(c));
    send(c);
    wait_drain("rst");
  endtask

  initial begin
    test_reset();
    test_local_write();
    test_local_read();
    test_ext_read();
    test_illegal_and_bounds();
    test_back_to_back();
    test_wait_bound();
    test_reset_in_wait();
    repeat (3) @(posedge clk);
    checks++;
    if (lcl_q.size() != 0 || ext_q.size() != 0 || ack_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got lcl=%0d ext=%0d ack=%0d required 0", lcl_q.size(), ext_q.size(), ack_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
